// File: rtl/alu_pkg.sv
// Shared opcode and FSM state definitions for the alu_exec datapath.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SHL = 3'd5,
      OP_SHR = 3'd6,
      OP_MUL = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_MUL  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic is_mul(input logic [2:0] code);
      return code == OP_MUL;
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential shift-add multiplier: one partial product per cycle,
// MAX_WIDTH iterations, done pulses the cycle after the last iteration.
module alu_mul_seq #(
   parameter int MAX_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [MAX_WIDTH-1:0]     mcand,
   input  logic [MAX_WIDTH-1:0]     mplier,
   output logic                     done,
   output logic [2*MAX_WIDTH-1:0]   product
);

   localparam int CW = $clog2(MAX_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(MAX_WIDTH - 1);

   logic [2*MAX_WIDTH-1:0] prod_reg;
   logic [2*MAX_WIDTH-1:0] prod_next;
   logic [MAX_WIDTH-1:0]   mcand_reg;
   logic [CW-1:0]          cnt_reg;
   logic                   run_reg;
   logic                   done_reg;
   logic [MAX_WIDTH:0]     upper_sum;

   // Multiplier sits in the low half and is consumed LSB first while the
   // accumulated upper half (with its carry) shifts down into it.
   assign upper_sum = {1'b0, prod_reg[2*MAX_WIDTH-1:MAX_WIDTH]} + {1'b0, mcand_reg};

   always_comb begin
      prod_next = {1'b0, prod_reg[2*MAX_WIDTH-1:1]};
      if (prod_reg[0])
         prod_next = {upper_sum, prod_reg[MAX_WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prod_reg  <= '0;
         mcand_reg <= '0;
         cnt_reg   <= '0;
         run_reg   <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         if (start) begin
            prod_reg  <= {{MAX_WIDTH{1'b0}}, mplier};
            mcand_reg <= mcand;
            cnt_reg   <= '0;
            run_reg   <= 1'b1;
         end else if (run_reg) begin
            prod_reg <= prod_next;
            cnt_reg  <= cnt_reg + 1'b1;
            if (cnt_reg == LAST) begin
               run_reg  <= 1'b0;
               done_reg <= 1'b1;
            end
         end
      end
   end

   assign done    = done_reg;
   assign product = prod_reg;

endmodule

// File: rtl/alu_exec.sv
// Small execution unit: single-cycle ALU ops plus a multi-cycle multiplier,
// producing a registered result/carry and a one-cycle flag-update strobe.
module alu_exec
   import alu_pkg::*;
#(
   parameter int MAX_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2:0]           op,
   input  logic [MAX_WIDTH-1:0] opa,
   input  logic [MAX_WIDTH-1:0] opb,
   output logic                 busy,
   output logic                 done,
   output logic [MAX_WIDTH-1:0] dataa,
   output logic                 carry,
   output logic                 enaf
);

   state_t                 state_reg;
   state_t                 state_next;
   op_t                    op_reg;
   logic [MAX_WIDTH-1:0]   a_reg;
   logic [MAX_WIDTH-1:0]   b_reg;
   logic                   accept;
   logic                   mul_start;
   logic                   mul_done;
   logic [2*MAX_WIDTH-1:0] mul_product;
   logic [MAX_WIDTH:0]     sum_ext;
   logic [MAX_WIDTH:0]     diff_ext;
   logic [MAX_WIDTH-1:0]   alu_res;
   logic                   alu_carry;

   assign accept    = (state_reg == ST_IDLE) && start;
   assign mul_start = accept && is_mul(op);

   alu_mul_seq #(.MAX_WIDTH(MAX_WIDTH)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .mcand   (opa),
      .mplier  (opb),
      .done    (mul_done),
      .product (mul_product)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: if (start) state_next = is_mul(op) ? ST_MUL : ST_EXEC;
         ST_EXEC: state_next = ST_DONE;
         ST_MUL:  if (mul_done) state_next = ST_DONE;
         ST_DONE: state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg == ST_EXEC) || (state_reg == ST_MUL);
      done = (state_reg == ST_DONE);
   end

   assign enaf = done;

   // Borrow falls out as bit MAX_WIDTH of the zero-extended difference.
   assign sum_ext  = {1'b0, a_reg} + {1'b0, b_reg};
   assign diff_ext = {1'b0, a_reg} - {1'b0, b_reg};

   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      case (op_reg)
         OP_ADD: {alu_carry, alu_res} = sum_ext;
         OP_SUB: {alu_carry, alu_res} = diff_ext;
         OP_AND: alu_res = a_reg & b_reg;
         OP_OR:  alu_res = a_reg | b_reg;
         OP_XOR: alu_res = a_reg ^ b_reg;
         OP_SHL: begin
            alu_res   = {a_reg[MAX_WIDTH-2:0], 1'b0};
            alu_carry = a_reg[MAX_WIDTH-1];
         end
         OP_SHR: begin
            alu_res   = {1'b0, a_reg[MAX_WIDTH-1:1]};
            alu_carry = a_reg[0];
         end
         default: begin
            alu_res   = '0;
            alu_carry = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_reg <= OP_ADD;
         a_reg  <= '0;
         b_reg  <= '0;
         dataa  <= '0;
         carry  <= 1'b0;
      end else begin
         if (accept) begin
            op_reg <= op_t'(op);
            a_reg  <= opa;
            b_reg  <= opb;
         end
         if (state_reg == ST_EXEC) begin
            dataa <= alu_res;
            carry <= alu_carry;
         end else if ((state_reg == ST_MUL) && mul_done) begin
            dataa <= mul_product[MAX_WIDTH-1:0];
            carry <= |mul_product[2*MAX_WIDTH-1:MAX_WIDTH];
         end
      end
   end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: stimulus pushes expected results from an
// arithmetic reference model, a negedge monitor pops and compares them.
module tb_alu_exec;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [2:0]   op = 3'd0;
   logic [W-1:0] opa = '0;
   logic [W-1:0] opb = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] dataa;
   logic         carry;
   logic         enaf;

   alu_exec #(.MAX_WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .opa   (opa),
      .opb   (opb),
      .busy  (busy),
      .done  (done),
      .dataa (dataa),
      .carry (carry),
      .enaf  (enaf)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] d;
      logic         c;
      int           due;
      int           opc;
      int           a;
      int           b;
   } exp_t;

   typedef struct {
      string name;
      int    act;
      int    exp;
   } chk_t;

   exp_t sb_q[$];
   chk_t chk_q[$];

   int checks = 0;
   int failures = 0;

   logic [W-1:0] last_d;
   logic         last_c;

   // Reference model: plain integer arithmetic on the opcode's meaning.
   function automatic void model(input int o, input int a, input int b,
                                 output logic [W-1:0] d, output logic c);
      int m = 1 << W;
      int r = 0;
      c = 1'b0;
      case (o)
         0: begin r = a + b; c = (r >= m); end
         1: begin r = a - b; c = (a < b); if (r < 0) r = r + m; end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: begin r = a * 2; c = (r >= m); end
         6: begin r = a / 2; c = (a % 2) != 0; end
         default: begin r = a * b; c = (r >= m); end
      endcase
      d = W'(r % m);
   endfunction

   function automatic void push_chk(input string n, input int a, input int e);
      chk_t k;
      k.name = n;
      k.act  = a;
      k.exp  = e;
      chk_q.push_back(k);
   endfunction

   // Monitor: drains direct checks, flags overdue/spurious results, and
   // compares each done pulse with the oldest scoreboard entry.
   always @(negedge clk) begin
      chk_t k;
      exp_t e;
      logic ok;
      while (chk_q.size() > 0) begin
         k = chk_q.pop_front();
         checks++;
         if (k.act != k.exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", k.name, k.act, k.exp, cyc);
         end
      end
      if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
         e = sb_q.pop_front();
         checks++;
         failures++;
         $display("FAIL overdue op=%0d a=%h b=%h: no done by cycle %0d (required at %0d)",
                  e.opc, e.a, e.b, cyc, e.due);
      end
      if (done) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL spurious_done: done=1 dataa=%h carry=%b at cycle %0d, none expected",
                     dataa, carry, cyc);
         end else begin
            e = sb_q.pop_front();
            ok = (dataa == e.d) && (carry == e.c) && (enaf == 1'b1) && (cyc == e.due);
            if (!ok) failures++;
            $display("%s txn op=%0d a=%h b=%h: got dataa=%h carry=%b enaf=%b cycle=%0d, required dataa=%h carry=%b enaf=1 cycle=%0d",
                     ok ? "PASS" : "FAIL", e.opc, e.a, e.b, dataa, carry, enaf, cyc, e.d, e.c, e.due);
         end
      end
   end

   // Issue one operation at the current negedge; operands are scrambled
   // right after acceptance.
   task automatic issue(input int o, input int a, input int b);
      exp_t e;
      logic [W-1:0] d;
      logic c;
      model(o, a, b, d, c);
      e.d   = d;
      e.c   = c;
      e.opc = o;
      e.a   = a;
      e.b   = b;
      e.due = cyc + ((o == 7) ? W + 2 : 2);
      sb_q.push_back(e);
      last_d = d;
      last_c = c;
      start = 1'b1;
      op    = 3'(o);
      opa   = W'(a);
      opb   = W'(b);
      @(negedge clk);
      start = 1'b0;
      op    = 3'($urandom);
      opa   = W'($urandom);
      opb   = W'($urandom);
      push_chk("busy_after_accept", int'(busy), 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (sb_q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) push_chk("wait_timeout", sb_q.size(), 0);
      @(negedge clk);
      push_chk("hold_dataa", int'(dataa), int'(last_d));
      push_chk("hold_carry", int'(carry), int'(last_c));
   endtask

   task automatic run_op(input int o, input int a, input int b);
      issue(o, a, b);
      wait_idle();
   endtask

   initial begin
      repeat (3) @(negedge clk);
      push_chk("rst_busy", int'(busy), 0);
      push_chk("rst_done", int'(done), 0);
      push_chk("rst_enaf", int'(enaf), 0);
      push_chk("rst_dataa", int'(dataa), 0);
      push_chk("rst_carry", int'(carry), 0);
      rst = 1'b1;
      @(negedge clk);
      push_chk("idle_busy", int'(busy), 0);

      run_op(0, 8'hFF, 8'h01);
      run_op(1, 8'h05, 8'h07);
      run_op(1, 8'h07, 8'h05);
      run_op(7, 8'h10, 8'h11);
      run_op(7, 8'h0F, 8'h03);
      run_op(5, 8'h81, 8'h00);
      run_op(6, 8'h81, 8'h00);
      run_op(7, 8'hFF, 8'hFF);
      run_op(1, 8'h00, 8'hFF);

      // Start pulse while the multiplier is running must be ignored.
      issue(7, 8'h10, 8'h11);
      repeat (2) @(negedge clk);
      start = 1'b1;
      op    = 3'd0;
      opa   = 8'h01;
      opb   = 8'h01;
      @(negedge clk);
      start = 1'b0;
      wait_idle();

      for (int i = 0; i < 40; i++)
         run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));

      // Reset in the middle of a multiply discards it.
      run_op(0, 8'h40, 8'h05);
      start = 1'b1;
      op    = 3'd7;
      opa   = 8'h33;
      opb   = 8'h55;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      push_chk("abort_dataa", int'(dataa), 0);
      push_chk("abort_carry", int'(carry), 0);
      push_chk("abort_busy", int'(busy), 0);
      push_chk("abort_done", int'(done), 0);
      push_chk("abort_enaf", int'(enaf), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      last_d = '0;
      last_c = 1'b0;
      run_op(0, 8'h01, 8'h02);

      repeat (15) @(negedge clk);
      push_chk("final_queue_empty", sb_q.size(), 0);
      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter: MAX_WIDTH, 8, operand/result width in bits (minimum 4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 op  input  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
REQ-006 opa  input  MAX_WIDTH  operand A, captured on accepted start.
REQ-007 opb  input  MAX_WIDTH  operand B, captured on accepted start.
REQ-008 busy  output  1  high from the cycle after acceptance until done.
REQ-009 done  output  1  one-cycle pulse when the result is valid.
REQ-010 dataa  output  MAX_WIDTH  registered result; feeds flag register dataa.
REQ-011 carry  output  1  registered carry/borrow/overflow; feeds flag register carry.
REQ-012 enaf  output  1  flag-update strobe; identical to done.

Function
REQ-013 FSM states: IDLE, EXEC, MUL, DONE; encoding is free.
REQ-014 IDLE with start=1 shall capture op, opa and opb, then go to MUL if op=7, else to EXEC.
REQ-015 IDLE with start=0 shall stay in IDLE; busy, done and enaf are 0.
REQ-016 EXEC shall compute the result in one cycle, load dataa and carry, and go to DONE.
REQ-017 ADD: {carry,dataa} = opa+opb over MAX_WIDTH+1 bits.
REQ-018 SUB: dataa = opa-opb mod 2^MAX_WIDTH; carry = 1 when opa<opb (borrow).
REQ-019 AND/OR/XOR: bitwise; carry = 0.
REQ-020 SHL: dataa = opa<<1, carry = opa[MSB]. SHR: dataa = opa>>1 (logical), carry = opa[0].
REQ-021 MUL: shift-add over exactly MAX_WIDTH iterations, one per cycle, with a 2*MAX_WIDTH-bit product register and an iteration counter.
REQ-022 MUL: at completion, dataa = low MAX_WIDTH bits; carry = 1 when any high bit is nonzero (overflow).
REQ-023 DONE shall assert done and enaf for exactly one cycle and return to IDLE.
REQ-024 A new start is accepted no earlier than the cycle after DONE; there is no back-to-back overlap.
REQ-025 Latency from the start cycle to the done pulse: 2 cycles for non-MUL ops; MAX_WIDTH+2 cycles for MUL.
REQ-026 start while busy shall be ignored, with no effect on captured operands or state.
REQ-027 dataa and carry shall hold their last values until the next result loads.
REQ-028 Operand changes after acceptance shall not affect the result.

Reset
REQ-029 Asserting rst at any time shall immediately force IDLE and clear busy, done, enaf, dataa, carry, the counter and the product register to 0.
REQ-030 An operation interrupted by reset shall be discarded; no enaf pulse is produced for it.
REQ-031 The first start is accepted on the first rising edge after rst deasserts.

Structure
REQ-032 Opcode constants and the FSM state encoding shall live in the shared package alu_pkg.
REQ-033 The multi-cycle multiplier shall be a sub-module alu_mul_seq, with start/done handshake, parameterised by MAX_WIDTH.
REQ-034 dataa, carry and enaf shall connect directly to the flag register without glue logic.

Verification
REQ-035 ADD opa=0xFF, opb=0x01 -> two cycles later: dataa=0x00, carry=1, enaf=1 for one cycle.
REQ-036 SUB opa=0x05, opb=0x07 -> dataa=0xFE, carry=1; SUB 0x07-0x05 -> dataa=0x02, carry=0.
REQ-037 MUL opa=0x10, opb=0x11 -> done 10 cycles after start with dataa=0x10, carry=1; MUL 0x0F*0x03 -> dataa=0x2D, carry=0.
REQ-038 During MUL, pulse start with op=0, opa=0x01, opb=0x01 -> ignored; MUL result unchanged; exactly one enaf pulse.
REQ-039 rst low at iteration 4 of MUL -> all outputs 0 immediately; no enaf pulse; after release, ADD 0x01+0x02 -> dataa=0x03.
REQ-040 SHL opa=0x81 -> dataa=0x02, carry=1; SHR opa=0x81 -> dataa=0x40, carry=1.
